// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo.
// The master side drives write data and both request enables; the slave
// side (the FIFO) returns registered read data and the status flags.
interface sync_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din_i;
  logic              wr_en_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] dout_o;
  logic              full_o;
  logic              empty_o;

  modport master (
    output din_i,
    output wr_en_i,
    output rd_en_i,
    input  dout_o,
    input  full_o,
    input  empty_o
  );

  modport slave (
    input  din_i,
    input  wr_en_i,
    input  rd_en_i,
    output dout_o,
    output full_o,
    output empty_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as a rate-decoupling queue between a producer and
// a consumer in one clock domain. Read data is registered; full/empty are
// decoded from registered pointers, so no input reaches an output
// combinationally. Pointers carry one extra wrap bit so that full and empty
// are distinguishable when the low (address) bits match.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  sync_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] dout_p1;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags from the registered pointers only.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  end

  // Request qualification. A write while full is still taken when a read
  // frees the oldest slot on the same edge; a read while empty is dropped,
  // which also means a simultaneous rd+wr on an empty FIFO only writes.
  always_comb begin
    rd_acc = bus.rd_en_i && !empty;
    wr_acc = bus.wr_en_i && (!full || bus.rd_en_i);
  end

  // ---- stage p0 -> p1: storage write, pointer update, read-data register

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= bus.din_i;
    end
  end

  // Write pointer, modulo 2*DEPTH via natural binary overflow.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer, modulo 2*DEPTH via natural binary overflow.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr <= '0;
    end else if (rd_acc) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Registered read data; holds its last value when no read is accepted.
  // On a full rd+wr the slot being read is also being written, and the
  // non-blocking read here returns the old (oldest) entry as required.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dout_p1 <= '0;
    end else if (rd_acc) begin
      dout_p1 <= mem[rd_ptr[AW-1:0]];
    end
  end

  // ---- outputs
  always_comb begin
    bus.dout_o  = dout_p1;
    bus.full_o  = full;
    bus.empty_o = empty;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=8, DATA_W=8): a table of fill/drain
// and simultaneous-at-empty vectors, followed by hand sequences for
// wrap-around, simultaneous-at-full and asynchronous mid-operation reset.
module tb_sync_fifo;

  logic clk_tb;
  logic rst_n_tb;
  int   checks;
  int   errors;

  sync_fifo_if #(.DATA_W(8)) bus ();

  sync_fifo #(.DEPTH(8), .DATA_W(8)) dut (
    .clk_i   (clk_tb),
    .reset_i (rst_n_tb),
    .bus     (bus)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [7:0] d, input logic f, input logic e);
    checks++;
    if (bus.dout_o !== d || bus.full_o !== f || bus.empty_o !== e) begin
      errors++;
      $display("FAIL %s: got dout=%02h full=%0b empty=%0b, want dout=%02h full=%0b empty=%0b",
               nm, bus.dout_o, bus.full_o, bus.empty_o, d, f, e);
    end
  endtask

  // Drive one set of requests between edges, sample 1 time unit after the edge.
  task automatic step(input logic wr, input logic rd, input logic [7:0] din);
    @(negedge clk_tb);
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.din_i   = din;
    @(posedge clk_tb);
    #1;
    @(negedge clk_tb);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  // step() returns at a negedge; sample right after the edge instead.
  task automatic op(input logic wr, input logic rd, input logic [7:0] din);
    @(negedge clk_tb);
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.din_i   = din;
    @(posedge clk_tb);
    #1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Fill: 8 writes of F0..F7, full rises on the 8th.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{wr: 1'b1, rd: 1'b0, din: 8'hF0 + 8'(i), dout: 8'h00,
                 full: (i == 7), empty: 1'b0};
    // 9th write while full is ignored.
    tbl[8] = '{wr: 1'b1, rd: 1'b0, din: 8'hAA, dout: 8'h00, full: 1'b1, empty: 1'b0};
    // Drain: F0..F7 in order, empty rises on the 8th read.
    for (int i = 0; i < 8; i++)
      tbl[9 + i] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, dout: 8'hF0 + 8'(i),
                     full: 1'b0, empty: (i == 7)};
    // 9th read while empty: dout holds F7.
    tbl[17] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, dout: 8'hF7, full: 1'b0, empty: 1'b1};
    // Simultaneous at empty: only the write happens.
    tbl[18] = '{wr: 1'b1, rd: 1'b1, din: 8'h3C, dout: 8'hF7, full: 1'b0, empty: 1'b0};
    tbl[19] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, dout: 8'h3C, full: 1'b0, empty: 1'b1};
    // Idle cycle: nothing changes.
    tbl[20] = '{wr: 1'b0, rd: 1'b0, din: 8'h99, dout: 8'h3C, full: 1'b0, empty: 1'b1};

    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.din_i   = 8'h00;
    rst_n_tb    = 1'b0;
    #12;
    chk("reset_asserted", 8'h00, 1'b0, 1'b1);
    @(negedge clk_tb);
    rst_n_tb = 1'b1;
    @(posedge clk_tb);
    #1;
    chk("reset_release", 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 21; i++) begin
      op(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("vec%0d", i), tbl[i].dout, tbl[i].full, tbl[i].empty);
    end

    // Wrap-around: pointers start at 9, so these cross the index wrap.
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, 8'h20 + 8'(i));
      chk($sformatf("wrap_w5_%0d", i), 8'h3C, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_r5_%0d", i), 8'h20 + 8'(i), 1'b0, (i == 4));
    end
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 1'b0, 8'h30 + 8'(i));
      chk($sformatf("wrap_w8_%0d", i), 8'h24, (i == 7), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_r8_%0d", i), 8'h30 + 8'(i), 1'b0, (i == 7));
    end

    // Simultaneous at full.
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 1'b0, 8'h10 + 8'(i));
      chk($sformatf("full_fill_%0d", i), 8'h37, (i == 7), 1'b0);
    end
    op(1'b1, 1'b1, 8'h55);
    chk("full_rdwr", 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      op(1'b0, 1'b1, 8'h00);
      chk($sformatf("full_drain_%0d", i), 8'h11 + 8'(i), 1'b0, 1'b0);
    end
    op(1'b0, 1'b1, 8'h00);
    chk("full_drain_last", 8'h55, 1'b0, 1'b1);

    // Asynchronous reset with 3 entries queued, checked before any edge.
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'h60 + 8'(i));
    chk("pre_reset_queued", 8'h55, 1'b0, 1'b0);
    rst_n_tb = 1'b0;
    #1;
    chk("async_reset", 8'h00, 1'b0, 1'b1);
    @(negedge clk_tb);
    rst_n_tb = 1'b1;
    op(1'b0, 1'b1, 8'h00);
    chk("post_reset_read_empty", 8'h00, 1'b0, 1'b1);
    op(1'b1, 1'b0, 8'h77);
    op(1'b0, 1'b1, 8'h00);
    chk("post_reset_roundtrip", 8'h77, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
